// File: rtl/nv_cdc_pkg.sv
// Shared encodings for the toggle-handshake CDC receiver: FSM states and the
// warm-up terminal count.
package nv_cdc_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_VALID = 2'd2
    } cdc_state_t;

    localparam logic [1:0] WARM_TC = 2'd3;

endpackage

// File: rtl/sync3d.sv
// Three-flop synchronizer cell for a single asynchronous bit. It has no reset,
// so the receiver ignores its output until the chain has flushed.
module sync3d (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        s1 <= d;
        s2 <= s1;
        q  <= s2;
    end

endmodule

// File: rtl/nv_sync3d_hs_rx.sv
// Destination side of a two-phase request/ack crossing. It captures the
// quasi-static source word on a request toggle and hands it out over valid/ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | sync chain warm-up; req_s_d tracks req_s, edges ignored
// ST_IDLE  | waiting for a request toggle
// ST_VALID | word held on dst_pd, waiting for dst_rdy
module nv_sync3d_hs_rx
    import nv_cdc_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          src_req_tgl,
    input  logic [DW-1:0] src_data,
    output logic          dst_ack_tgl,
    output logic          dst_vld,
    input  logic          dst_rdy,
    output logic [DW-1:0] dst_pd,
    output logic [CW-1:0] xfer_cnt,
    output logic          proto_err
);

    logic       req_s;
    logic       req_s_d;
    logic       req_edge;
    logic [1:0] warm_cnt;
    cdc_state_t state;

    sync3d u_sync_req (
        .clk (nvdla_core_clk),
        .d   (src_req_tgl),
        .q   (req_s)
    );

    assign req_edge = req_s ^ req_s_d;

    // src_data is captured unsynchronized; it is stable whenever req_edge fires.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= ST_INIT;
            warm_cnt    <= 2'd0;
            req_s_d     <= 1'b0;
            dst_ack_tgl <= 1'b0;
            dst_vld     <= 1'b0;
            dst_pd      <= '0;
            xfer_cnt    <= '0;
            proto_err   <= 1'b0;
        end else begin
            req_s_d <= req_s;
            case (state)
                ST_INIT: begin
                    if (warm_cnt == WARM_TC) begin
                        state <= ST_IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end
                ST_IDLE: begin
                    if (req_edge) begin
                        dst_pd  <= src_data;
                        dst_vld <= 1'b1;
                        state   <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // A second toggle before our ack is a source violation; it is dropped.
                    if (req_edge) begin
                        proto_err <= 1'b1;
                    end
                    if (dst_rdy) begin
                        dst_vld     <= 1'b0;
                        dst_ack_tgl <= ~dst_ack_tgl;
                        xfer_cnt    <= xfer_cnt + CW'(1);
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nv_sync3d_hs_rx.sv
// Self-checking bench for nv_sync3d_hs_rx: a cycle-level behavioural model of the
// handshake is compared against the DUT every cycle, plus directed literal checks.
module tb_nv_sync3d_hs_rx;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tgl;
    logic [DW-1:0] sdata;
    logic          rdy;
    logic          ack;
    logic          vld;
    logic [DW-1:0] pd;
    logic [CW-1:0] cnt;
    logic          err;

    int n_chk = 0;
    int n_fail = 0;

    nv_sync3d_hs_rx #(.DW(DW), .CW(CW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .src_req_tgl     (tgl),
        .src_data        (sdata),
        .dst_ack_tgl     (ack),
        .dst_vld         (vld),
        .dst_rdy         (rdy),
        .dst_pd          (pd),
        .xfer_cnt        (cnt),
        .proto_err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: a toggle on the source is seen three clocks later, and
    // the first four clocks after reset release are warm-up where nothing is seen.
    logic [7:0]    hist;
    int            m_cyc;
    logic          m_vld;
    logic [DW-1:0] m_pd;
    logic          m_ack;
    logic [CW-1:0] m_cnt;
    logic          m_err;
    logic          seen;

    always @(posedge clk) hist <= {hist[6:0], tgl};

    assign seen = hist[2] ^ hist[3];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cyc <= 0;
            m_vld <= 1'b0;
            m_pd  <= '0;
            m_ack <= 1'b0;
            m_cnt <= '0;
            m_err <= 1'b0;
        end else if (m_cyc < 4) begin
            m_cyc <= m_cyc + 1;
        end else if (m_vld) begin
            if (seen) m_err <= 1'b1;
            if (rdy) begin
                m_vld <= 1'b0;
                m_ack <= ~m_ack;
                m_cnt <= m_cnt + 1'b1;
            end
        end else if (seen) begin
            m_vld <= 1'b1;
            m_pd  <= sdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model_vld", 32'(vld), 32'(m_vld));
        chk("model_pd",  pd,       m_pd);
        chk("model_ack", 32'(ack), 32'(m_ack));
        chk("model_cnt", 32'(cnt), 32'(m_cnt));
        chk("model_err", 32'(err), 32'(m_err));
    endtask

    task automatic wait_vld(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld && n < max);
        if (!vld) chk("vld_timeout", 32'(vld), 32'd1);
    endtask

    int            n;
    int            vc;
    int            k;
    logic          stable;
    logic [DW-1:0] d;

    initial begin
        rstn = 1'b0; tgl = 1'b1; sdata = '0; rdy = 1'b0;
        repeat (5) tick();
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_pd",  pd,       32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // source held at 1 through reset: must not look like a request
        rstn = 1'b1;
        vc = 0;
        repeat (20) begin tick(); if (vld) vc++; end
        chk("warm_no_vld", 32'(vc), 32'd0);
        chk("warm_err", 32'(err), 32'd0);

        rstn = 1'b0; tgl = 1'b0;
        repeat (5) tick();
        rstn = 1'b1;
        repeat (8) tick();

        // basic transfer, ready held high
        sdata = 32'hDEADBEEF; rdy = 1'b1; tgl = 1'b1;
        wait_vld(10, n);
        chk("first_latency", 32'(n), 32'd4);
        chk("first_pd", pd, 32'hDEADBEEF);
        tick();
        chk("first_vld_pulse", 32'(vld), 32'd0);
        chk("first_ack", 32'(ack), 32'd1);
        chk("first_cnt", 32'(cnt), 32'd1);

        // backpressure
        rdy = 1'b0; sdata = 32'h11223344; tgl = ~tgl;
        wait_vld(10, n);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!vld || pd !== 32'h11223344 || ack !== 1'b1) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        rdy = 1'b1;
        tick();
        chk("hold_accept_vld", 32'(vld), 32'd0);
        chk("hold_accept_ack", 32'(ack), 32'd0);
        chk("hold_accept_cnt", 32'(cnt), 32'd2);

        // double toggle before ack
        rdy = 1'b0; sdata = 32'hA5A5_0001; tgl = ~tgl;
        wait_vld(10, n);
        sdata = 32'h5A5A_0002; tgl = ~tgl;
        repeat (6) tick();
        chk("viol_err", 32'(err), 32'd1);
        chk("viol_pd", pd, 32'hA5A5_0001);
        chk("viol_vld", 32'(vld), 32'd1);
        rdy = 1'b1;
        tick();
        chk("viol_ack", 32'(ack), 32'd1);
        chk("viol_cnt", 32'(cnt), 32'd3);
        vc = 0;
        repeat (8) begin tick(); if (vld) vc++; end
        chk("viol_dropped", 32'(vc), 32'd0);
        chk("viol_sticky", 32'(err), 32'd1);

        // async reset with a word pending
        rdy = 1'b0; sdata = 32'h55AA_77EE; tgl = ~tgl;
        wait_vld(10, n);
        #2 rstn = 1'b0;
        #1;
        chk("arst_vld", 32'(vld), 32'd0);
        chk("arst_pd",  pd,       32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        vc = 0;
        repeat (20) begin tick(); if (vld) vc++; end
        chk("arst_no_spurious", 32'(vc), 32'd0);
        sdata = 32'hCAFEF00D; rdy = 1'b1; tgl = ~tgl;
        wait_vld(10, n);
        chk("arst_next_pd", pd, 32'hCAFEF00D);
        tick();
        chk("arst_next_cnt", 32'(cnt), 32'd1);
        chk("arst_next_ack", 32'(ack), 32'd1);

        // 17 compliant random transfers: counter wraps back to 1
        rstn = 1'b0; tgl = 1'b0; rdy = 1'b0;
        repeat (5) tick();
        rstn = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 17; i++) begin
            d = $urandom;
            sdata = d; tgl = ~tgl;
            wait_vld(12, n);
            chk("rand_pd", pd, d);
            k = $urandom_range(0, 3);
            repeat (k) tick();
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            k = $urandom_range(0, 2);
            repeat (k) tick();
        end
        chk("rand_cnt_wrap", 32'(cnt), 32'd1);
        chk("rand_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
